rr_arb_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit round-robin arbitrated multiplexer with valid/ready handshakes on every input and one registered output.
- Generalises the fixed 4:1 64-bit select mux: the select is generated internally by a fair rotating arbiter, and the output is held in a pipeline register with backpressure.
- Sits between multiple requesters (e.g. memory-port clients, writeback sources) and a single shared consumer in the pipelined CPU datapath.

---
 rtl/rr_arb_mux_pkg.sv | 21 ++
 rtl/rr_arbiter_pick.sv | 47 ++++
 rtl/rr_arb_mux.sv | 116 +++++++++++
 tb/tb_rr_arb_mux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arb_mux_pkg                                               |
// | Description : Shared defaults and helpers for the round-robin arbitrated   |
// |               multiplexer (default channel count, data width and the       |
// |               channel-index width helper).                                 |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package rr_arb_mux_pkg;

    localparam int RR_N_DEF     = 4;
    localparam int RR_WIDTH_DEF = 64;

    // Width needed to index n channels.
    function automatic int chan_w(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter_pick                                              |
// | Description : Combinational rotating-priority picker. Scans req starting  |
// |               at index ptr, increasing modulo N; the first set bit wins.   |
// | Ports       : req   [N]      request vector                                |
// |               ptr   [CHAN_W] highest-priority index for this cycle         |
// |               grant [N]      one-hot winner, zero when no request          |
// |               idx   [CHAN_W] binary index of the winner                    |
// |               any            at least one request is set                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_arbiter_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int N      = RR_N_DEF,
    parameter int CHAN_W = chan_w(N)
) (
    input  logic [N-1:0]      req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [N-1:0]      grant,
    output logic [CHAN_W-1:0] idx,
    output logic              any
);

    logic [CHAN_W-1:0] w_j;
    logic              w_found;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo keeps the scan inside the legal range for non-power-of-2 N.
            w_j = CHAN_W'((int'(ptr) + k) % N);
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = w_j;
            end
        end
        any = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arb_mux                                                   |
// | Description : N-channel, WIDTH-bit round-robin arbitrated multiplexer with |
// |               valid/ready on every input and one registered output beat.   |
// |               Optional burst lock: define RR_ARB_MUX_LOCK_EN to hold the   |
// |               grant on a channel until it transfers a beat with in_last.   |
// | Ports       : clk, reset (sync, active-high)                               |
// |               in_valid/in_data/in_last/in_ready : N request channels       |
// |               out_valid/out_data/out_chan/out_ready : registered output    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N      = RR_N_DEF,
    parameter int WIDTH  = RR_WIDTH_DEF,
    parameter int CHAN_W = chan_w(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          in_valid,
    input  logic [WIDTH-1:0]      in_data [N-1:0],
    input  logic [N-1:0]          in_last,
    output logic [N-1:0]          in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CHAN_W-1:0]     out_chan,
    input  logic                  out_ready
);

    logic [CHAN_W-1:0] r_ptr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [CHAN_W-1:0] r_out_chan;

    logic [N-1:0]      w_req;
    logic [N-1:0]      w_grant;
    logic [CHAN_W-1:0] w_idx;
    logic              w_any;
    logic              w_load;
    logic              w_xfer;
    logic              w_adv;
    logic [CHAN_W-1:0] w_next_ptr;

`ifdef RR_ARB_MUX_LOCK_EN
    logic              r_locked;
    logic [CHAN_W-1:0] r_lock_chan;

    // While a burst is open only its owner may request; if the owner drops
    // valid mid-burst nobody gets in_ready.
    assign w_req = r_locked ? (in_valid & (N'(1) << r_lock_chan)) : in_valid;
    assign w_adv = in_last[w_idx];
`else
    logic w_unused_last;

    assign w_req         = in_valid;
    assign w_adv         = 1'b1;
    assign w_unused_last = ^in_last;
`endif

    rr_arbiter_pick #(
        .N      (N),
        .CHAN_W (CHAN_W)
    ) u_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // Register may take a new beat when empty or being drained this cycle.
    assign w_load     = !r_out_valid || out_ready;
    assign in_ready   = reset ? '0 : (w_grant & {N{w_load}});
    assign w_xfer     = !reset && w_load && w_any;
    assign w_next_ptr = (w_idx == CHAN_W'(N - 1)) ? '0 : (w_idx + CHAN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_idx];
                r_out_chan  <= w_idx;
                if (w_adv) begin
                    r_ptr <= w_next_ptr;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked    <= 1'b0;
            r_lock_chan <= '0;
        end else if (w_xfer) begin
            r_locked    <= !in_last[w_idx];
            r_lock_chan <= w_idx;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rr_arb_mux                                                |
// | Description : Directed self-checking bench for rr_arb_mux (N=4, WIDTH=64). |
// |               A reference model predicts in_ready and pushes each expected |
// |               beat to a scoreboard queue; beats are popped when the        |
// |               output register is expected to load them.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rr_arb_mux;

    typedef struct {
        logic [1:0]  chan;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [63:0] in_data [3:0];
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_chan;
    logic        out_ready;

    int tests  = 0;
    int failed = 0;

    beat_t q[$];

    // Reference model state
    logic        m_valid     = 1'b0;
    logic [63:0] m_data      = '0;
    logic [1:0]  m_chan      = '0;
    logic [1:0]  m_ptr       = '0;
    logic        m_locked    = 1'b0;
    logic [1:0]  m_lock_chan = '0;

    logic [1:0]  exp_seq [5];

    rr_arb_mux #(
        .N     (4),
        .WIDTH (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check in_ready, clock, check outputs.
    task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] last,
                        input logic rst);
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
        logic [1:0] j;
        logic       any;
        logic       load;
        logic       xfer;
        logic       adv;
        beat_t      b;
        reset     = rst;
        in_valid  = v;
        out_ready = rdy;
        in_last   = last;
        #1;
        req = v;
        if (m_locked) req = v & (4'b0001 << m_lock_chan);
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            j = m_ptr + 2'(k);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
        load = !m_valid || rdy;
        xfer = !rst && load && any;
        check("in_ready", 64'(in_ready), rst ? 64'd0 : 64'(grant & {4{load}}));
        if (xfer) q.push_back('{idx, in_data[idx]});
        @(posedge clk);
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_chan   = '0;
            m_ptr    = '0;
            m_locked = 1'b0;
        end else if (load) begin
            if (xfer) begin
                b       = q.pop_front();
                m_chan  = b.chan;
                m_data  = b.data;
                m_valid = 1'b1;
                adv     = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
                adv         = last[idx];
                m_locked    = !last[idx];
                m_lock_chan = idx;
`endif
                if (adv) m_ptr = idx + 2'd1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_chan",  64'(out_chan),  64'(m_chan));
        check("out_data",  out_data,       m_data);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = 64'hA0 + 64'(i);
`ifdef RR_ARB_MUX_LOCK_EN
        exp_seq = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
`else
        exp_seq = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
`endif
        @(negedge clk);

        // Reset with all requests active
        step(4'b1111, 1'b1, 4'b0000, 1'b1);
        step(4'b1111, 1'b1, 4'b0000, 1'b1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,       64'd0);

        // Round-robin sweep
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, 4'b0000, 1'b0);
            check("sweep_chan",  64'(out_chan),  64'(k % 4));
            check("sweep_data",  out_data,       64'hA0 + 64'(k % 4));
            check("sweep_valid", 64'(out_valid), 64'd1);
        end

        // Sparse requests and pointer wrap
        step(4'b0100, 1'b1, 4'b0000, 1'b0);
        check("sparse_c2", 64'(out_chan), 64'd2);
        step(4'b0011, 1'b1, 4'b0000, 1'b0);
        check("wrap_c0", 64'(out_chan), 64'd0);
        step(4'b0011, 1'b1, 4'b0000, 1'b0);
        check("wrap_c1", 64'(out_chan), 64'd1);
        step(4'b0011, 1'b1, 4'b0000, 1'b0);
        check("wrap_c0b", 64'(out_chan), 64'd0);

        // Backpressure, then drain and refill in one cycle with fresh data
        for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b0, 4'b0000, 1'b0);
            check("bp_hold_chan", 64'(out_chan), 64'd0);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        step(4'b0100, 1'b1, 4'b0000, 1'b0);
        check("refill_c2", 64'(out_chan), 64'd2);
        check("refill_data", out_data, in_data[2]);

        // Mid-stream reset with ptr at 2
        step(4'b0010, 1'b1, 4'b0000, 1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        step(4'b1111, 1'b1, 4'b0000, 1'b1);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        step(4'b0101, 1'b1, 4'b0000, 1'b0);
        check("post_rst_c0", 64'(out_chan), 64'd0);

        // Burst from channel 1 with channels 0 and 3 competing
        step(4'b1011, 1'b1, 4'b0000, 1'b0);
        check("burst_0", 64'(out_chan), 64'(exp_seq[0]));
        step(4'b1011, 1'b1, 4'b0000, 1'b0);
        check("burst_1", 64'(out_chan), 64'(exp_seq[1]));
        step(4'b1011, 1'b1, 4'b1111, 1'b0);
        check("burst_2", 64'(out_chan), 64'(exp_seq[2]));
        step(4'b1011, 1'b1, 4'b1111, 1'b0);
        check("burst_3", 64'(out_chan), 64'(exp_seq[3]));
        step(4'b1011, 1'b1, 4'b1111, 1'b0);
        check("burst_4", 64'(out_chan), 64'(exp_seq[4]));

        // Idle: register empties, data holds
        step(4'b0000, 1'b1, 4'b0000, 1'b0);
        check("idle_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
